do_tanso: RTL and testbench

- Frequency/period meter: the measuring counterpart of the team's clock dividers.
- Samples a slow asynchronous signal (divided clock, 1 Hz tick, external pulse train) in the clk_50MHz domain and reports the number of clk_50MHz cycles between consecutive rising edges.
- Used to self-check divider outputs and to measure external references in the decade clock design.

---
 rtl/do_tanso_if.sv | 28 ++
 rtl/do_tanso.sv | 150 +++++++++++++++
 tb/tb_do_tanso.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/do_tanso_if.sv
// ---------------------------------------------------------------------------
// do_tanso_if -- signal bundle for the do_tanso frequency/period meter.
//   sig_in        : asynchronous signal to measure (driven by master)
//   period_out    : last measured period in clk_50MHz cycles
//   period_valid  : one-cycle pulse when period_out updates
//   locked        : consecutive edges arriving within TIMEOUT
//   timeout_flag  : sticky timeout indication
// modport slave is the meter side, modport master is the stimulus/user side.
// ---------------------------------------------------------------------------
interface do_tanso_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             timeout_flag;

  modport master (
    output sig_in,
    input  period_out, period_valid, locked, timeout_flag
  );

  modport slave (
    input  sig_in,
    output period_out, period_valid, locked, timeout_flag
  );
endinterface

// File: rtl/do_tanso.sv
// ---------------------------------------------------------------------------
// do_tanso -- frequency/period meter.
// Samples a slow asynchronous signal in the clk_50MHz domain and reports the
// number of clk_50MHz cycles between consecutive rising edges.
//
// Ports:
//   clk_50MHz : system clock, the only clock
//   rst       : synchronous, active-high reset
//   bus       : do_tanso_if.slave (sig_in in; period_out, period_valid,
//               locked, timeout_flag out)
//
// Parameters:
//   CNT_W       : period counter / period_out width
//   TIMEOUT     : cycles without a rising edge before giving up (< 2^CNT_W)
//   SYNC_STAGES : synchronizer depth (>= 2)
//
// Optional build macro DO_TANSO_AVG4_EN: report the running average of the
// last 4 periods instead of every individual period (one extra cycle of
// latency; first report only after 4 periods have been collected).
//
// Latency sig_in rise -> period_valid is SYNC_STAGES+2 cycles, constant, so
// the start and stop edges see the same delay and periods are exact.
// ---------------------------------------------------------------------------
module do_tanso #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  do_tanso_if.slave   bus
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_pout;
  logic                   r_pvalid;
  logic                   r_locked;
  logic                   r_tflag;
  logic                   w_sync_out;

`ifdef DO_TANSO_AVG4_EN
  logic [CNT_W-1:0]       r_hist [4];
  logic [CNT_W+1:0]       r_sum;
  logic [2:0]             r_hcnt;
  logic                   r_avg_pend;
`endif

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
      r_pout   <= '0;
      r_pvalid <= 1'b0;
      r_locked <= 1'b0;
      r_tflag  <= 1'b0;
`ifdef DO_TANSO_AVG4_EN
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      r_sum      <= '0;
      r_hcnt     <= '0;
      r_avg_pend <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
      r_prev <= w_sync_out;
      // Registered edge pulse: adds a fixed cycle, but keeps the FSM off the
      // synchronizer output path.
      r_rise <= w_sync_out & ~r_prev;

      r_pvalid <= 1'b0;
`ifdef DO_TANSO_AVG4_EN
      // Extra stage: publish the sum updated on the previous cycle.
      r_avg_pend <= 1'b0;
      if (r_avg_pend) begin
        r_pout   <= r_sum[CNT_W+1:2];
        r_pvalid <= 1'b1;
      end
`endif

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r_rise) begin
            r_cnt   <= ONE;
            r_state <= ARMED;
          end
        end

        ARMED, MEASURE: begin
          // Edge has priority over timeout, so a period of exactly TIMEOUT
          // is still reported.
          if (r_rise) begin
`ifdef DO_TANSO_AVG4_EN
            r_hist[0] <= r_cnt;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            r_hist[3] <= r_hist[2];
            r_sum     <= r_sum + (CNT_W+2)'(r_cnt) - (CNT_W+2)'(r_hist[3]);
            if (r_hcnt != 3'd4) r_hcnt <= r_hcnt + 3'd1;
            r_avg_pend <= (r_hcnt >= 3'd3);
`else
            r_pout   <= r_cnt;
            r_pvalid <= 1'b1;
`endif
            r_locked <= 1'b1;
            r_tflag  <= 1'b0;
            r_cnt    <= ONE;
            r_state  <= MEASURE;
          end else if (r_cnt == TO_CNT) begin
            r_tflag  <= 1'b1;
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_state  <= IDLE;
`ifdef DO_TANSO_AVG4_EN
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_sum  <= '0;
            r_hcnt <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.period_out   = r_pout;
  assign bus.period_valid = r_pvalid;
  assign bus.locked       = r_locked;
  assign bus.timeout_flag = r_tflag;

endmodule

// File: tb/tb_do_tanso.sv
// ---------------------------------------------------------------------------
// tb_do_tanso -- bench for do_tanso (TIMEOUT=1000, SYNC_STAGES=2).
// Reference model works on input rising-edge times: a rise at input cycle n
// reports n - (previous rise) once the pipeline delay has elapsed; a gap of
// TIMEOUT cycles without a rise abandons the measurement.
// ---------------------------------------------------------------------------
module tb_do_tanso;
  localparam int CNT_W = 32;
  localparam int TMO   = 1000;
  localparam int SS    = 2;
  localparam int LAT   = SS + 2;

  typedef struct {
    logic [CNT_W-1:0] per;
    logic             vld;
    logic             lck;
    logic             tf;
  } exp_t;

  logic clk_50MHz = 1'b0;
  logic rst;
  always #10 clk_50MHz = ~clk_50MHz;

  do_tanso_if #(.CNT_W(CNT_W)) bus ();

  do_tanso #(.CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   vc     = 0;
  exp_t q[$];

  // model state
  bit               m_have;
  int               m_last;
  logic             m_prev;
  logic [CNT_W-1:0] m_per;
  logic             m_lck, m_tf;

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs,
                     input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_t z;
    m_have = 0; m_last = 0; m_prev = 1'b0;
    m_per = '0; m_lck = 1'b0; m_tf = 1'b0;
    z.per = '0; z.vld = 1'b0; z.lck = 1'b0; z.tf = 1'b0;
    q.delete();
    repeat (LAT) q.push_back(z);
  endtask

  // One clock: drive sig_in, advance the model, compare outputs against the
  // expectation computed LAT cycles earlier.
  task automatic cycle(input logic s);
    exp_t e;
    logic rise;
    @(posedge clk_50MHz); #1;
    bus.sig_in = s;
    cyc++;
    rise   = s & ~m_prev;
    m_prev = s;
    e.vld  = 1'b0;
    if (rise) begin
      if (m_have) begin
        m_per = CNT_W'(cyc - m_last);
        e.vld = 1'b1;
        m_lck = 1'b1;
        m_tf  = 1'b0;
      end
      m_have = 1;
      m_last = cyc;
    end else if (m_have && (cyc - m_last) == TMO) begin
      m_tf   = 1'b1;
      m_lck  = 1'b0;
      m_have = 0;
    end
    e.per = m_per; e.lck = m_lck; e.tf = m_tf;
    q.push_back(e);
    @(negedge clk_50MHz);
    if (bus.period_valid === 1'b1) vc++;
    if (q.size() > LAT) begin
      e = q.pop_front();
      chk("period_out",   bus.period_out,           e.per);
      chk("period_valid", CNT_W'(bus.period_valid), CNT_W'(e.vld));
      chk("locked",       CNT_W'(bus.locked),       CNT_W'(e.lck));
      chk("timeout_flag", CNT_W'(bus.timeout_flag), CNT_W'(e.tf));
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < per; j++) cycle(j < hi);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_50MHz); #1;
    rst = 1'b1;
    bus.sig_in = 1'b0;
    @(posedge clk_50MHz); #1;
    @(negedge clk_50MHz);
    chk("rst period_out",   bus.period_out,           '0);
    chk("rst period_valid", CNT_W'(bus.period_valid), '0);
    chk("rst locked",       CNT_W'(bus.locked),       '0);
    chk("rst timeout_flag", CNT_W'(bus.timeout_flag), '0);
    @(posedge clk_50MHz); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int p, h;
    rst = 1'b1;
    bus.sig_in = 1'b0;
    model_clear();
    do_reset();

    // square wave 10/10
    vc = 0;
    wave(20, 10, 6);
    chk("sq period", bus.period_out, 20);
    chk("sq locked", CNT_W'(bus.locked), 1);
    chk("sq count",  CNT_W'(vc), 5);

    // duty cycle 3/17
    vc = 0;
    wave(20, 3, 6);
    chk("duty period", bus.period_out, 20);
    chk("duty count",  CNT_W'(vc), 6);

    // timeout, then recovery at period 50
    idle(1010);
    chk("to flag",   CNT_W'(bus.timeout_flag), 1);
    chk("to locked", CNT_W'(bus.locked), 0);
    chk("to period", bus.period_out, 20);
    wave(50, 5, 2);
    idle(10);
    chk("recover period", bus.period_out, 50);
    chk("recover flag",   CNT_W'(bus.timeout_flag), 0);

    // reset 7 cycles after an edge
    wave(20, 10, 2);
    cycle(1'b1);
    repeat (6) cycle(1'b0);
    do_reset();
    vc = 0;
    wave(20, 10, 3);
    chk("post-rst count", CNT_W'(vc), 2);

    // boundary: spacing exactly TMO, then TMO+1
    cycle(1'b1);
    repeat (9) cycle(1'b0);
    vc = 0;
    repeat (990) cycle(1'b0);
    cycle(1'b1);
    repeat (10) cycle(1'b0);
    chk("bnd period", bus.period_out, TMO);
    chk("bnd flag",   CNT_W'(bus.timeout_flag), 0);
    chk("bnd count",  CNT_W'(vc), 1);
    vc = 0;
    repeat (990) cycle(1'b0);
    cycle(1'b1);
    repeat (10) cycle(1'b0);
    chk("bnd+1 flag",   CNT_W'(bus.timeout_flag), 1);
    chk("bnd+1 count",  CNT_W'(vc), 0);
    chk("bnd+1 period", bus.period_out, TMO);

    // random periods, including the 2-cycle minimum and one long gap
    repeat (40) begin
      p = $urandom_range(2, 60);
      h = $urandom_range(1, p - 1);
      wave(p, h, 1);
    end
    idle($urandom_range(900, 1100));
    repeat (20) begin
      p = $urandom_range(2, 40);
      h = $urandom_range(1, p - 1);
      wave(p, h, 1);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
